// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch squash,
// memory-not-ready freeze with a watchdog that latches a sticky error.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_id,
  input  logic [4:0]       rm_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rn_id,
  input  logic             uses_rm_id,
  input  logic             uses_rd_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_ERR = 1'b1} state_t;

  localparam logic [15:0] LP_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_freeze;
  logic w_lu;
  logic w_stall_inc;
  logic w_flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_freeze = mem_req_mem & ~mem_ready;
  // XZR (X31) is never a real producer, so it can never cause a load-use stall.
  assign w_lu = memread_ex & (rd_ex != 5'd31) &
                ((uses_rn_id & (rn_id == rd_ex)) |
                 (uses_rm_id & (rm_id == rd_ex)) |
                 (uses_rd_id & (rd_id == rd_ex)));

  assign w_stall_inc = (r_state == S_RUN) & (w_freeze | (~branch_taken_ex & w_lu));
  assign w_flush_inc = (r_state == S_RUN) & ~w_freeze & branch_taken_ex;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      if ((r_state == S_ERR) || w_freeze) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else if (branch_taken_ex) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 16'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_freeze) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
        if (r_wait_cnt == LP_WAIT_LAST) r_state <= S_ERR;
      end else begin
        r_wait_cnt <= 16'd0;
      end
      if (w_stall_inc) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_inc) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign mem_err   = (r_state == S_ERR);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
